// File: rtl/a0_trace_pkg.sv
// Shared types and constants for the a0 trace capture buffer.
// No logic; widths here are defaults that the top can override.
// No flow control of its own.
package a0_trace_pkg;

    localparam int STAMP_W_DEF = 16;
    localparam logic [7:0] DROP_MAX = 8'd255;

    typedef struct packed {
        logic [31:0]            value;
        logic [STAMP_W_DEF-1:0] stamp;
    } trace_rec_t;

endpackage

// File: rtl/a0_trace_fifo_fifo.sv
// Generic synchronous FIFO of records with count-derived full/empty.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: push is accepted when not full, or when full and popping on the same edge.
module trace_fifo
    import a0_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter type rec_t = trace_rec_t,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  rec_t          push_dat,
    output logic          full,
    input  logic          pop,
    output rec_t          pop_dat,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    rec_t          mem [DEPTH];
    rec_t          last_q;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            last_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                last_q <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: it is only read through the head mux while non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    assign pop_dat = empty ? last_q : mem[rd_ptr];
    assign count   = cnt;

endmodule

// File: rtl/a0_trace_fifo.sv
// Records every change of the core's a0 register into a drainable FIFO; stamps need A0_TRACE_STAMP_EN.
// Latency: a change sampled at edge k is at the head after edge k when the FIFO was empty.
// Backpressure: never stalls the core; records arriving while full without a pop are dropped and counted.
module a0_trace_fifo
    import a0_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int STAMP_W = STAMP_W_DEF,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trace_en,
    input  logic [31:0]        a0,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_value,
    output logic [STAMP_W-1:0] out_stamp,
    output logic [CW-1:0]      count,
    output logic               overflow,
    output logic [7:0]         drop_cnt
);

`ifdef A0_TRACE_STAMP_EN
    typedef struct packed {
        logic [31:0]        value;
        logic [STAMP_W-1:0] stamp;
    } rec_t;
    logic [STAMP_W-1:0] stamp_q;
`else
    typedef struct packed {
        logic [31:0] value;
    } rec_t;
`endif

    logic [31:0] prev_a0;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic        ovf_q;
    logic [7:0]  drop_q;
    rec_t        push_rec;
    rec_t        head_rec;

    assign push      = trace_en && (a0 != prev_a0);
    assign pop       = out_valid && out_ready;
    assign out_valid = !empty;

    always_comb begin
        push_rec       = '0;
        push_rec.value = a0;
`ifdef A0_TRACE_STAMP_EN
        push_rec.stamp = stamp_q;
`endif
    end

    // prev_a0 tracks a0 even while disabled, so changes made then are never replayed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_a0 <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            prev_a0 <= a0;
            if (push && full && !pop) begin
                ovf_q <= 1'b1;
                if (drop_q != DROP_MAX) drop_q <= drop_q + 8'd1;
            end
        end
    end

`ifdef A0_TRACE_STAMP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stamp_q <= '0;
        else      stamp_q <= stamp_q + STAMP_W'(1);
    end
    assign out_stamp = head_rec.stamp;
`else
    assign out_stamp = '0;
`endif

    trace_fifo #(
        .DEPTH (DEPTH),
        .rec_t (rec_t)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_rec),
        .full     (full),
        .pop      (pop),
        .pop_dat  (head_rec),
        .empty    (empty),
        .count    (count)
    );

    assign out_value = head_rec.value;
    assign overflow  = ovf_q;
    assign drop_cnt  = drop_q;

endmodule
